param_digital_clock: RTL
========================

Name: param_digital_clock

Overview:
Parametrised successor to the team's minutes/seconds clock. Keeps 24-hour time (hours/minutes/seconds) advanced by an internal prescaler. Adds count enable, synchronous time load, 12/24-hour display mode and a single armed alarm. Sits between the system clock domain and display/alarm logic.

Parameters:
TICKS_PER_SEC, 1, clk cycles per second; 1 = every enabled cycle is a second; legal range >= 1.
PRESC_W, $clog2(TICKS_PER_SEC)+1, prescaler counter width (derived; do not override).

Ports:
clk  in  1  single clock; all state on posedge.
reset  in  1  synchronous, active-high.
en  in  1  count enable; 0 freezes prescaler and time.
mode_12h  in  1  1 = 12-hour display encoding, 0 = 24-hour.
load  in  1  one-cycle strobe: load time from load_* inputs.
load_hours  in  5  0..23.
load_minutes  in  6  0..59.
load_seconds  in  6  0..59.
alarm_set  in  1  one-cycle strobe: store and arm alarm from alarm_* inputs.
alarm_hours  in  5  0..23.
alarm_minutes  in  6  0..59.
alarm_ack  in  1  clears alarm.
seconds  out  6  0..59.
minutes  out  6  0..59.
hours  out  5  internal 24-hour value, 0..23.
disp_hours  out  5  hours per mode_12h.
pm  out  1  1 when hours >= 12 (both modes).
sec_tick  out  1  one-cycle pulse, asserted in the cycle the new second value is visible.
alarm  out  1  sticky alarm flag.
load_err  out  1  one-cycle pulse on a rejected load/alarm_set.

Behaviour:
- Reset (synchronous, highest priority): time 00:00:00, prescaler 0, alarm regs 00:00, armed 0, alarm 0, sec_tick 0, load_err 0.
- Prescaler:
  - When en=1, counts 0..TICKS_PER_SEC-1 and wraps.
  - A tick occurs in the cycle en=1 and prescaler==TICKS_PER_SEC-1.
  - With TICKS_PER_SEC=1, every en=1 cycle is a tick.
  - en=0 holds the prescaler value; no tick.
- Tick: seconds+1. 59 -> 0 with minutes+1. Minutes 59 -> 0 with hours+1. Hours 23 -> 0, so 23:59:59 -> 00:00:00.
- Updated time and sec_tick=1 are visible one cycle after the tick cycle.
- Priority per cycle: reset > load > tick.
- Load:
  - Valid load: time <= load_* at the next edge, prescaler <= 0.
  - A tick in the same cycle is discarded; no sec_tick.
  - Valid regardless of en.
- Validation: hours > 23, minutes > 59 or seconds > 59 rejects the load. Time and prescaler are unchanged, a same-cycle tick still proceeds, and load_err pulses for 1 cycle.
- alarm_set:
  - Valid: alarm regs <= alarm_*, armed <= 1.
  - Invalid (hours > 23 or minutes > 59): regs and armed unchanged, load_err pulses.
  - Independent of load. If both are invalid in the same cycle, load_err is a single pulse.
- Alarm fire:
  - Occurs when armed=1 and a tick produces time == alarm_hours:alarm_minutes:00. Fires on ticks only, never on load.
  - alarm <= 1 in the same cycle the new time is visible.
  - armed stays 1, so the alarm re-fires 24 h later.
- alarm_ack clears alarm at the next edge. If a fire and alarm_ack occur in the same cycle, the fire wins (alarm=1).
- disp_hours (combinational from the hours register):
  - mode_12h=0: equals hours.
  - mode_12h=1: 0 -> 12, 1..12 -> unchanged, 13..23 -> hours-12.
- mode_12h may change any cycle; it affects display only, never state.
- Reset asserted mid-count or mid-alarm returns everything to reset values at that edge.

Decomposition:
- Package clock_pkg: constants MAX_SEC=59, MAX_MIN=59, MAX_HR=23; typedef struct packed time_t {hours[4:0], minutes[5:0], seconds[5:0]}; function time_valid(time_t); function to_12h(hours) returning disp_hours.
- Sub-module tick_prescaler (parameter TICKS_PER_SEC; ports clk, reset, en, clear, tick) isolates the divider.
- Time/alarm logic stays in param_digital_clock.

Test Plan:
- TICKS_PER_SEC=4, en=1 from reset -> first sec_tick after 4 cycles (seconds=1); seconds=59 -> 0 with minutes 0 -> 1.
- Load 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00; pm 1 -> 0; disp_hours with mode_12h=1 goes 11 -> 12.
- Load 25:00:00 -> load_err pulses once, time unchanged and still counting; load 12:30:00 with a coincident tick -> exactly 12:30:00, no sec_tick.
- en=0 for 10 cycles mid-second -> no change; en=1 resumes from the held prescaler count (tick after the remaining cycles).
- alarm_set 01:02, load 01:01:58, 2 ticks -> alarm=1 at 01:02:00; alarm_ack on the same cycle as a re-fire -> alarm stays 1; ack alone -> 0.
- Assert reset while alarm=1 at 13:45:10 -> all outputs 0 and armed=0 next cycle; counting to 01:02:00 raises no alarm.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time type, field limits and conversion helpers for the digital clock.
// The type and helpers are common to the clock top and its testbench.
package clock_pkg;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_HR  = 5'd23;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } time_t;

  function automatic logic time_valid(input time_t t);
    return (t.hours <= MAX_HR) && (t.minutes <= MAX_MIN) && (t.seconds <= MAX_SEC);
  endfunction

  // 12-hour display: midnight/noon both show 12; afternoon hours fold down by 12.
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0)
      r = 5'd12;
    else if (h > 5'd12)
      r = h - 5'd12;
    else
      r = h;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the enabled clock down to one tick per TICKS_PER_SEC enabled cycles.
// Implemented as a down-counter: remaining cycles until the terminal count of zero.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRESC_W       = $clog2(TICKS_PER_SEC) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] RELOAD = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] remain;

  assign tick = en && (remain == '0);

  // clear restarts a full second, overriding any same-cycle count or wrap.
  always_ff @(posedge clk) begin
    if (reset)
      remain <= RELOAD;
    else if (clear)
      remain <= RELOAD;
    else if (en) begin
      if (remain == '0)
        remain <= RELOAD;
      else
        remain <= remain - 1'b1;
    end
  end

endmodule

// File: rtl/param_digital_clock.sv
// 24-hour clock with prescaled seconds, count enable, validated time load,
// 12/24-hour display encoding and a single re-arming alarm.
module param_digital_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRESC_W       = $clog2(TICKS_PER_SEC) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_ack,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm,
  output logic       load_err
);

  time_t cur;
  time_t inc;
  time_t load_t;
  time_t alarm_in;
  time_t alarm_r;
  logic  armed;
  logic  presc_tick;
  logic  load_ok;
  logic  load_bad;
  logic  alarm_ok;
  logic  alarm_bad;
  logic  do_tick;
  logic  fire;

  assign load_t   = '{hours: load_hours, minutes: load_minutes, seconds: load_seconds};
  assign alarm_in = '{hours: alarm_hours, minutes: alarm_minutes, seconds: 6'd0};

  assign load_ok   = load && time_valid(load_t);
  assign load_bad  = load && !time_valid(load_t);
  assign alarm_ok  = alarm_set && time_valid(alarm_in);
  assign alarm_bad = alarm_set && !time_valid(alarm_in);

  // A valid load swallows a coincident tick; a rejected load lets it through.
  assign do_tick = presc_tick && !load_ok;
  assign fire    = do_tick && armed && (inc == alarm_r);

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .PRESC_W       (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (load_ok),
    .tick  (presc_tick)
  );

  always_comb begin
    inc = cur;
    if (cur.seconds == MAX_SEC) begin
      inc.seconds = 6'd0;
      if (cur.minutes == MAX_MIN) begin
        inc.minutes = 6'd0;
        inc.hours   = (cur.hours == MAX_HR) ? 5'd0 : cur.hours + 5'd1;
      end else begin
        inc.minutes = cur.minutes + 6'd1;
      end
    end else begin
      inc.seconds = cur.seconds + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= '0;
      alarm_r  <= '0;
      armed    <= 1'b0;
      alarm    <= 1'b0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (load_ok)
        cur <= load_t;
      else if (do_tick)
        cur <= inc;

      sec_tick <= do_tick;
      load_err <= load_bad || alarm_bad;

      if (alarm_ok) begin
        alarm_r <= alarm_in;
        armed   <= 1'b1;
      end

      // A fire beats a same-cycle acknowledge so no alarm event is lost.
      if (fire)
        alarm <= 1'b1;
      else if (alarm_ack)
        alarm <= 1'b0;
    end
  end

  assign seconds    = cur.seconds;
  assign minutes    = cur.minutes;
  assign hours      = cur.hours;
  assign pm         = (cur.hours >= 5'd12);
  assign disp_hours = mode_12h ? to_12h(cur.hours) : cur.hours;

endmodule
